// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_rca4bit.sv
// 4-bit ripple-carry adder: the only arithmetic datapath element of the serial adder.
module RCA4bit (
    output logic [3:0] Sum,
    output logic       Cout,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        Sum  = '0;
        c[0] = Cin;
        for (int i = 0; i < 4; i++) begin
            Sum[i]   = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        Cout = c[4];
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder controller: one 4-bit slice per RUN cycle, LSB nibble first.
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid to latch operands
// RUN   | one nibble added per cycle, counter selects the slice
// DONE  | Sum/Cout valid and held until out_ready
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] A,
    input  logic [NIBBLE_W*NIBBLES-1:0] B,
    input  logic                        Cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] Sum,
    output logic                        Cout,
    output logic                        busy
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int CNT_W = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_t           state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W+1:0] sel;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       s_nib;
    logic             c_nib;

    // Slice base bit = cnt * 4, formed by wiring rather than an adder.
    assign sel   = {cnt, 2'b00};
    assign a_nib = a_q[sel +: NIBBLE_W];
    assign b_nib = b_q[sel +: NIBBLE_W];

    RCA4bit u_rca (
        .Sum  (s_nib),
        .Cout (c_nib),
        .A    (a_nib),
        .B    (b_nib),
        .Cin  (carry_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            Sum       <= '0;
            Cout      <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        carry_q  <= Cin;
                        cnt      <= '0;
                        Sum      <= '0;
                        Cout     <= 1'b0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    Sum[sel +: NIBBLE_W] <= s_nib;
                    carry_q              <= c_nib;
                    // Counter parks on the last slice instead of wrapping.
                    if (cnt == LAST) begin
                        Cout      <= c_nib;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and back-to-back checks of the nibble-serial adder controller.
module tb_serial_add_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        A        = a;
        B        = b;
        Cin      = c;
        in_valid = 1'b1;
    endtask

    logic [W:0] exp_res;
    int         n;
    int         acc;
    int         prev;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        Cin       = 1'b0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_cout", Cout, 0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", in_ready, 1);

        // 1 + 2: latency of exactly N RUN edges
        out_ready = 1'b1;
        present(16'h0001, 16'h0002, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_in_ready", in_ready, 0);
        for (int i = 0; i < N - 1; i++) begin
            tick();
            chk("t1_early_valid", out_valid, 0);
        end
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_busy_done", busy, 0);
        chk("t1_sum", Sum, 16'h0003);
        chk("t1_cout", Cout, 0);
        tick();
        chk("t1_back_idle", in_ready, 1);

        // FFFF + 1: carry ripples through every nibble
        present(16'hFFFF, 16'h0001, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            tick();
            chk("t2_carry", dut.carry_q, 1);
        end
        chk("t2_valid", out_valid, 1);
        chk("t2_sum", Sum, 16'h0000);
        chk("t2_cout", Cout, 1);
        tick();

        // 8 + 8 + 1
        present(16'h0008, 16'h0008, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t3_carry_nib1", dut.carry_q, 1);
        for (int i = 0; i < N - 1; i++) tick();
        chk("t3_valid", out_valid, 1);
        chk("t3_sum", Sum, 16'h0011);
        chk("t3_cout", Cout, 0);
        tick();

        // DONE hold with pending request
        out_ready = 1'b0;
        present(16'h1234, 16'h1111, 1'b0);
        tick();
        present(16'hAAAA, 16'h5555, 1'b1);
        for (int i = 0; i < N; i++) tick();
        chk("t4_valid", out_valid, 1);
        chk("t4_sum", Sum, 16'h2345);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_sum", Sum, 16'h2345);
            chk("t4_hold_cout", Cout, 0);
            chk("t4_hold_in_ready", in_ready, 0);
            chk("t4_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        chk("t4_rel_in_ready", in_ready, 1);
        chk("t4_rel_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("t4_new_busy", busy, 1);
        for (int i = 0; i < N; i++) tick();
        chk("t4_new_valid", out_valid, 1);
        chk("t4_new_sum", Sum, 16'h0000);
        chk("t4_new_cout", Cout, 1);
        tick();

        // reset in the second RUN cycle
        present(16'h0F0F, 16'h0101, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_in_ready", in_ready, 1);
        chk("t5_busy", busy, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_sum", Sum, 0);
        chk("t5_cout", Cout, 0);
        chk("t5_carry", dut.carry_q, 0);
        for (int i = 0; i < N + 1; i++) begin
            tick();
            chk("t5_no_pulse", out_valid, 0);
        end

        // back-to-back random requests
        out_ready = 1'b1;
        prev      = 0;
        for (int i = 0; i < 1000; i++) begin
            present(W'($urandom), W'($urandom), 1'($urandom));
            exp_res = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin};
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            chk("b2b_ready", in_ready, 1);
            tick();
            acc = cyc;
            if (i > 0) chk("b2b_gap", acc - prev, N + 2);
            prev = acc;
            n = 0;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            chk("b2b_valid", out_valid, 1);
            chk("b2b_result", {Cout, Sum}, exp_res);
        end
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices per operand; legal range 2..8.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port in_valid  input  1  request carries valid operands.
REQ-005 Port in_ready  output  1  controller can accept a request.
REQ-006 Port A  input  4*NIBBLES  operand A, unsigned.
REQ-007 Port B  input  4*NIBBLES  operand B, unsigned.
REQ-008 Port Cin  input  1  carry into least-significant nibble.
REQ-009 Port out_valid  output  1  Sum/Cout hold a completed result.
REQ-010 Port out_ready  input  1  consumer takes the result.
REQ-011 Port Sum  output  4*NIBBLES  result, registered.
REQ-012 Port Cout  output  1  carry out of most-significant nibble, registered.
REQ-013 Port busy  output  1  high while state is RUN.

Function
REQ-014 States SHALL be IDLE, RUN, DONE; encoding from the shared package.
REQ-015 in_ready SHALL equal (state==IDLE); busy SHALL equal (state==RUN); out_valid SHALL equal (state==DONE).
REQ-016 Accept on an edge with IDLE and in_valid: latch A, B into operand registers, Cin into carry register, clear nibble counter, clear Sum and Cout, go to RUN.
REQ-017 Each RUN cycle SHALL drive the single 4-bit adder with A[4i+3:4i], B[4i+3:4i] and the carry register, where i = counter.
REQ-018 Each RUN edge: write adder sum into Sum[4i+3:4i], load adder carry-out into carry register, increment counter.
REQ-019 On the RUN edge with counter==NIBBLES-1: also load Cout from adder carry-out, go to DONE.
REQ-020 Latency: acceptance at edge k gives out_valid high after edge k+NIBBLES; exactly NIBBLES RUN cycles, no extra pipeline stage.
REQ-021 DONE SHALL hold Sum, Cout stable until an edge with out_ready high; that edge returns to IDLE.
REQ-022 No request SHALL be accepted in RUN or DONE; in_valid there is ignored and input operands are not sampled.
REQ-023 Operand registers SHALL NOT change during RUN or DONE, regardless of A, B, Cin.
REQ-024 Arithmetic is modulo 2^(4*NIBBLES); the final carry is reported only on Cout, never wrapped into Sum.
REQ-025 Counter width SHALL be clog2(NIBBLES); it SHALL NOT wrap past NIBBLES-1 within one operation.
REQ-026 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-027 rst high on an edge SHALL force IDLE, counter 0, carry register 0, operand registers 0, Sum 0, Cout 0, in any state.
REQ-028 Reset mid-RUN or in DONE SHALL discard the operation with no out_valid pulse; in_ready is 1 on the first cycle after rst deasserts.
REQ-029 rst SHALL take priority over in_valid and out_ready on the same edge.

Structure
REQ-030 Shared package SHALL hold the state type (IDLE, RUN, DONE) and constant NIBBLE_W = 4.
REQ-031 Exactly one sub-module SHALL be instantiated: RCA4bit (Sum, Cout, A, B, Cin), the team's 4-bit ripple-carry adder, used unmodified.
REQ-032 No other arithmetic on operand bits outside RCA4bit; control logic SHALL be pure counter/FSM.

Verification
REQ-033 A=0x0001, B=0x0002, Cin=0, out_ready=1 -> out_valid 4 cycles after accept, Sum=0x0003, Cout=0.
REQ-034 A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1; the carry register is 1 after each RUN edge.
REQ-035 A=0x0008, B=0x0008, Cin=1 -> Sum=0x0011, Cout=0; second RUN cycle sees carry register 1.
REQ-036 Hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> Sum/Cout unchanged, in_ready=0, no accept; release gives IDLE next cycle, then the new request is accepted.
REQ-037 Assert rst during the 2nd RUN cycle -> next cycle state IDLE, Sum=0, Cout=0, out_valid=0, in_ready=1, busy=0.
REQ-038 Back-to-back: in_valid held high, out_ready=1, random operands over 1000 requests -> every result matches the reference sum {Cout,Sum}=A+B+Cin; accept spacing is NIBBLES+2 cycles.
